fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage core: owns the program counter, drives the instruction-memory address, and buffers fetched instructions in a small prefetch queue. It feeds the IF pipeline register, which captures `if_pc`/`if_inst` each cycle. It absorbs `stall_flag` without dropping fetches and redirects to the branch target on `branch_flag`, flushing all wrong-path instructions.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: entry layout,
// NOP encoding and branch-target arithmetic.
package fetch_pkg;

   localparam int PC_W   = 5;
   localparam int INST_W = 32;

   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   // Offsets are in instruction words; the result wraps within the 5-bit PC space.
   function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc,
                                                     input logic            dir,
                                                     input logic [PC_W-1:0] off);
      return dir ? (pc - off) : (pc + off);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of fetch entries with synchronous flush; the head
// entry is presented combinationally.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  fetch_entry_t push_entry_i,
   output fetch_entry_t head_o,
   output logic [CNT_W-1:0] count_o
);

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   fetch_entry_t     mem_q [DEPTH];

   // Pointers wrap naturally because DEPTH is a power of two. A push into a
   // full queue is only issued together with a pop, so it reuses the head slot.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC ownership, prefetch queue and branch redirect.
// Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_bubbles counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 2,
   parameter logic [PC_W-1:0] RESET_PC = 5'd0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [INST_W-1:0] imem_inst,
   input  logic              stall_flag,
   input  logic              branch_flag,
   input  logic [PC_W-1:0]   branch_pc,
   input  logic              branch_direction,
   input  logic [PC_W-1:0]   branch_offset,
   output logic              if_valid,
   output logic [PC_W-1:0]   if_pc,
   output logic [INST_W-1:0] if_inst
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [7:0]        perf_fetched,
   output logic [7:0]        perf_bubbles
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] count;
   logic             push, pop;
   fetch_entry_t     head, new_entry;

   assign imem_addr = fetch_pc_q;
   assign if_valid  = (count != '0);

   // A redirect suppresses both sides of the queue for the cycle; stall is moot.
   assign pop  = if_valid & ~stall_flag & ~branch_flag;
   assign push = ~branch_flag & ((count < CNT_W'(DEPTH)) | pop);

   assign new_entry.pc   = fetch_pc_q;
   assign new_entry.inst = imem_inst;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (branch_flag)
         fetch_pc_d = branch_target(branch_pc, branch_direction, branch_offset);
      else if (push)
         fetch_pc_d = fetch_pc_q + PC_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fetch_pc_q <= RESET_PC;
      else        fetch_pc_q <= fetch_pc_d;
   end

   fetch_queue #(
      .DEPTH(DEPTH)
   ) u_queue (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (branch_flag),
      .push_i       (push),
      .pop_i        (pop),
      .push_entry_i (new_entry),
      .head_o       (head),
      .count_o      (count)
   );

   assign if_pc   = if_valid ? head.pc   : '0;
   assign if_inst = if_valid ? head.inst : NOP_INST;

`ifdef FETCH_PERF_CNT_EN
   logic [7:0] perf_fetched_q, perf_fetched_d;
   logic [7:0] perf_bubbles_q, perf_bubbles_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_bubbles_d = perf_bubbles_q;
      if (pop && (perf_fetched_q != 8'hFF))       perf_fetched_d = perf_fetched_q + 8'd1;
      if (!if_valid && (perf_bubbles_q != 8'hFF)) perf_bubbles_d = perf_bubbles_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_q <= '0;
         perf_bubbles_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_bubbles_q <= perf_bubbles_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// stall/branch traffic against a queue-level reference model.
module tb_fetch_unit;

   localparam int         DEPTH    = 2;
   localparam logic [4:0] RESET_PC = 5'd0;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  imem_addr;
   logic [31:0] imem_inst;
   logic        stall_flag = 1'b0;
   logic        branch_flag = 1'b0;
   logic [4:0]  branch_pc = '0;
   logic        branch_direction = 1'b0;
   logic [4:0]  branch_offset = '0;
   logic        if_valid;
   logic [4:0]  if_pc;
   logic [31:0] if_inst;
`ifdef FETCH_PERF_CNT_EN
   logic [7:0]  perf_fetched;
   logic [7:0]  perf_bubbles;
`endif

   fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem_addr        (imem_addr),
      .imem_inst        (imem_inst),
      .stall_flag       (stall_flag),
      .branch_flag      (branch_flag),
      .branch_pc        (branch_pc),
      .branch_direction (branch_direction),
      .branch_offset    (branch_offset),
      .if_valid         (if_valid),
      .if_pc            (if_pc),
      .if_inst          (if_inst)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched     (perf_fetched),
      .perf_bubbles     (perf_bubbles)
`endif
   );

   always #5 clk = ~clk;

   logic [31:0] mem [32];
   assign imem_inst = mem[imem_addr];

   typedef struct {
      int          pc;
      logic [31:0] inst;
   } ent_t;

   ent_t mq[$];
   int   mpc;
   int   m_fetched;
   int   m_bubbles;
   int   checks = 0;
   int   errors = 0;

   function automatic int sat255(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   function automatic void model_reset();
      mq.delete();
      mpc       = int'(RESET_PC);
      m_fetched = 0;
      m_bubbles = 0;
   endfunction

   // Drive one cycle of inputs, advance the reference model at the edge,
   // and return 1 time unit after the edge for sampling.
   task automatic tick(input logic s, input logic b, input logic [4:0] bp,
                       input logic d, input logic [4:0] off);
      bit full, do_pop;
      stall_flag       = s;
      branch_flag      = b;
      branch_pc        = bp;
      branch_direction = d;
      branch_offset    = off;
      @(posedge clk);
      if (rst_n && mq.size() == 0) m_bubbles = sat255(m_bubbles + 1);
      if (b) begin
         mq.delete();
         mpc = d ? ((int'(bp) - int'(off) + 32) % 32) : ((int'(bp) + int'(off)) % 32);
      end else begin
         full   = (mq.size() == DEPTH);
         do_pop = (mq.size() > 0) && !s;
         if (do_pop) begin
            void'(mq.pop_front());
            m_fetched = sat255(m_fetched + 1);
         end
         if (!full || do_pop) begin
            mq.push_back('{mpc, mem[mpc]});
            mpc = (mpc + 1) % 32;
         end
      end
      #1;
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", if_valid); end
      checks++; if (if_pc !== 5'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", if_pc); end
      checks++; if (if_inst !== NOP) begin errors++; $display("FAIL reset_inst got %h want %h", if_inst, NOP); end
      checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %0d want %0d", imem_addr, RESET_PC); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (perf_fetched !== 8'd0 || perf_bubbles !== 8'd0) begin
         errors++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_fetched, perf_bubbles);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      idle();
      checks++; if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin
         errors++; $display("FAIL first_fetch got v=%0b pc=%0d want v=1 pc=%0d", if_valid, if_pc, RESET_PC);
      end
      checks++; if (if_inst !== mem[RESET_PC]) begin errors++; $display("FAIL first_inst got %h want %h", if_inst, mem[RESET_PC]); end
   endtask

   task automatic test_sequential();
      for (int i = 1; i <= 40; i++) begin
         idle();
         checks++; if (if_valid !== 1'b1 || if_pc !== 5'(i % 32)) begin
            errors++; $display("FAIL seq_pc[%0d] got v=%0b pc=%0d want v=1 pc=%0d", i, if_valid, if_pc, i % 32);
         end
         checks++; if (if_inst !== mem[i % 32]) begin
            errors++; $display("FAIL seq_inst[%0d] got %h want %h", i, if_inst, mem[i % 32]);
         end
      end
   endtask

   task automatic test_stall();
      tick(1'b0, 1'b1, 5'd0, 1'b0, 5'd3);
      idle();
      checks++; if (if_pc !== 5'd3) begin errors++; $display("FAIL stall_setup got %0d want 3", if_pc); end
      for (int k = 0; k < 4; k++) begin
         tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
         checks++; if (if_valid !== 1'b1 || if_pc !== 5'd3) begin
            errors++; $display("FAIL stall_hold[%0d] got v=%0b pc=%0d want v=1 pc=3", k, if_valid, if_pc);
         end
         checks++; if (imem_addr !== 5'd5) begin errors++; $display("FAIL stall_addr[%0d] got %0d want 5", k, imem_addr); end
      end
      for (int k = 1; k <= 3; k++) begin
         idle();
         checks++; if (if_valid !== 1'b1 || if_pc !== 5'(3 + k)) begin
            errors++; $display("FAIL stall_release[%0d] got v=%0b pc=%0d want v=1 pc=%0d", k, if_valid, if_pc, 3 + k);
         end
      end
   endtask

   task automatic test_branch_fwd();
      tick(1'b0, 1'b1, 5'd10, 1'b0, 5'd6);
      checks++; if (if_valid !== 1'b0 || if_inst !== NOP || if_pc !== 5'd0) begin
         errors++; $display("FAIL br_fwd_bubble got v=%0b pc=%0d inst=%h want v=0 pc=0 inst=%h", if_valid, if_pc, if_inst, NOP);
      end
      idle();
      checks++; if (if_valid !== 1'b1 || if_pc !== 5'd16) begin
         errors++; $display("FAIL br_fwd_target got v=%0b pc=%0d want v=1 pc=16", if_valid, if_pc);
      end
   endtask

   task automatic test_branch_back();
      tick(1'b0, 1'b1, 5'd2, 1'b1, 5'd5);
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_back_bubble got %0b want 0", if_valid); end
      for (int k = 0; k < 4; k++) begin
         idle();
         checks++; if (if_valid !== 1'b1 || if_pc !== 5'((29 + k) % 32)) begin
            errors++; $display("FAIL br_back_seq[%0d] got v=%0b pc=%0d want v=1 pc=%0d", k, if_valid, if_pc, (29 + k) % 32);
         end
      end
   endtask

   task automatic test_branch_stall_full();
      tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
      tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
      checks++; if (if_pc !== 5'd0 || imem_addr !== 5'd2) begin
         errors++; $display("FAIL bs_full got pc=%0d addr=%0d want pc=0 addr=2", if_pc, imem_addr);
      end
      tick(1'b1, 1'b1, 5'd20, 1'b0, 5'd7);
      checks++; if (if_valid !== 1'b0 || imem_addr !== 5'd27) begin
         errors++; $display("FAIL bs_flush got v=%0b addr=%0d want v=0 addr=27", if_valid, imem_addr);
      end
      idle();
      checks++; if (if_valid !== 1'b1 || if_pc !== 5'd27) begin
         errors++; $display("FAIL bs_target got v=%0b pc=%0d want v=1 pc=27", if_valid, if_pc);
      end
   endtask

   task automatic test_random();
      logic        e_valid;
      logic [4:0]  e_pc;
      logic [31:0] e_inst;
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
              5'($urandom), 1'($urandom), 5'($urandom));
         e_valid = (mq.size() != 0);
         e_pc    = e_valid ? 5'(mq[0].pc) : 5'd0;
         e_inst  = e_valid ? mq[0].inst : NOP;
         checks++; if (if_valid !== e_valid || if_pc !== e_pc || if_inst !== e_inst) begin
            errors++; $display("FAIL rand_head[%0d] got v=%0b pc=%0d inst=%h want v=%0b pc=%0d inst=%h",
                               i, if_valid, if_pc, if_inst, e_valid, e_pc, e_inst);
         end
         checks++; if (imem_addr !== 5'(mpc)) begin
            errors++; $display("FAIL rand_addr[%0d] got %0d want %0d", i, imem_addr, mpc);
         end
`ifdef FETCH_PERF_CNT_EN
         checks++; if (perf_fetched !== 8'(m_fetched) || perf_bubbles !== 8'(m_bubbles)) begin
            errors++; $display("FAIL rand_perf[%0d] got %0d/%0d want %0d/%0d", i, perf_fetched, perf_bubbles, m_fetched, m_bubbles);
         end
`endif
      end
   endtask

   task automatic test_async_reset();
      tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
      tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
      tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (if_valid !== 1'b0 || if_pc !== 5'd0 || if_inst !== NOP) begin
         errors++; $display("FAIL async_rst_head got v=%0b pc=%0d inst=%h want v=0 pc=0 inst=%h", if_valid, if_pc, if_inst, NOP);
      end
      checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL async_rst_addr got %0d want %0d", imem_addr, RESET_PC); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (perf_fetched !== 8'd0 || perf_bubbles !== 8'd0) begin
         errors++; $display("FAIL async_rst_perf got %0d/%0d want 0/0", perf_fetched, perf_bubbles);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      checks++; if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin
         errors++; $display("FAIL async_rst_restart got v=%0b pc=%0d want v=1 pc=%0d", if_valid, if_pc, RESET_PC);
      end
      idle();
      checks++; if (if_pc !== RESET_PC + 5'd1) begin errors++; $display("FAIL async_rst_next got %0d want %0d", if_pc, RESET_PC + 5'd1); end
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_perf_saturation();
      for (int i = 0; i < 300; i++) tick(1'b0, 1'b1, 5'($urandom), 1'($urandom), 5'($urandom));
      checks++; if (perf_bubbles !== 8'd255 || perf_bubbles !== 8'(m_bubbles)) begin
         errors++; $display("FAIL perf_bubbles_sat got %0d want 255 (model %0d)", perf_bubbles, m_bubbles);
      end
      checks++; if (perf_fetched !== 8'(m_fetched)) begin
         errors++; $display("FAIL perf_fetched_hold got %0d want %0d", perf_fetched, m_fetched);
      end
   endtask
`endif

   initial begin
      for (int a = 0; a < 32; a++) mem[a] = $urandom;
      model_reset();
      test_reset();
      test_sequential();
      test_stall();
      test_branch_fwd();
      test_branch_back();
      test_branch_stall_full();
      test_random();
      test_async_reset();
`ifdef FETCH_PERF_CNT_EN
      test_perf_saturation();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
